rr_arb4_enc: RTL and testbench

Four-requester round-robin arbiter with an active-low enable. It shares a single downstream resource between four requesters. The grant is held until the owner releases it or a hold-time limit expires. It outputs a one-hot grant plus its 2-bit encoded index, in the same format as the team's 4-to-2 encoders.

---
 rtl/rr_arb_pkg.sv | 20 ++
 rtl/rot_pri_enc4.sv | 28 ++
 rtl/rr_arb4_enc.sv | 107 ++++++++++
 tb/tb_rr_arb4_enc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
// Widths here are fixed by the four-way requester count.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rot_pri_enc4.sv
// Rotating priority encoder: returns the first set request at or after ptr,
// wrapping modulo four, and flags whether any request was set.
module rot_pri_enc4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  logic [IDX_W-1:0] w_pos;

  // Scan from the farthest offset down so the nearest set bit is the last write.
  always_comb begin
    idx   = '0;
    hit   = 1'b0;
    w_pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = ptr + IDX_W'(k);
      if (req[w_pos]) begin
        idx = w_pos;
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_enc.sv
// Four-requester round-robin arbiter with hold-time limit and active-low enable.
// Outputs a registered one-hot grant plus its encoded index and a timeout pulse.
module rr_arb4_enc
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  // Handshake: a requester raises req[i] and keeps it high while gnt[i] is set;
  // dropping it releases the resource at the next edge. gnt is only ever
  // issued from IDLE, so every grant end is followed by one idle cycle.

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_vld;
  logic             r_timeout;

  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_hit;

  rot_pri_enc4 u_pri_enc (
    .req (req),
    .ptr (r_ptr),
    .idx (w_win_idx),
    .hit (w_win_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_gnt_vld <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!en_n && w_win_hit) begin
            r_state   <= BUSY;
            r_cnt     <= '0;
            r_gnt     <= idx_to_onehot(w_win_idx);
            r_gnt_idx <= w_win_idx;
            r_gnt_vld <= 1'b1;
          end
        end
        BUSY: begin
          if (en_n) begin
            // Abort leaves the pointer alone so the same owner wins next time.
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
          end else if (!req[r_gnt_idx]) begin
            r_state   <= IDLE;
            r_ptr     <= r_gnt_idx + IDX_W'(1);
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= IDLE;
            r_ptr     <= r_gnt_idx + IDX_W'(1);
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_gnt     <= '0;
          r_gnt_idx <= '0;
          r_gnt_vld <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign gnt_vld = r_gnt_vld;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Bench for rr_arb4_enc: two instances (HOLD_MAX 8 and 4) share stimulus and
// are checked by vector tables, hand sequences and a behavioural model.
module tb_rr_arb4_enc;

  logic       clk;
  logic       rst_n;
  logic       en_n;
  logic [3:0] req;

  logic [3:0] o_gnt [2];
  logic [1:0] o_idx [2];
  logic       o_vld [2];
  logic       o_to  [2];

  int n_cmp = 0;
  int n_bad = 0;

  rr_arb4_enc #(.HOLD_MAX(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .req(req),
    .gnt(o_gnt[0]), .gnt_idx(o_idx[0]), .gnt_vld(o_vld[0]), .timeout(o_to[0])
  );

  rr_arb4_enc #(.HOLD_MAX(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .req(req),
    .gnt(o_gnt[1]), .gnt_idx(o_idx[1]), .gnt_vld(o_vld[1]), .timeout(o_to[1])
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural reference: owner number, visible-cycle count, pointer
  int m_owner [2];
  int m_ptr   [2];
  int m_held  [2];
  bit m_to    [2];
  bit m_live = 1'b0;
  int hold_of [2] = '{8, 4};

  always @(posedge clk) begin
    int found;
    for (int d = 0; d < 2; d++) begin
      m_to[d] = 1'b0;
      if (!rst_n) begin
        m_owner[d] = -1; m_ptr[d] = 0; m_held[d] = 0;
      end else if (m_owner[d] < 0) begin
        found = -1;
        for (int off = 0; off < 4; off++)
          if (found < 0 && req[(m_ptr[d] + off) % 4]) found = (m_ptr[d] + off) % 4;
        if (!en_n && found >= 0) begin
          m_owner[d] = found; m_held[d] = 1;
        end
      end else if (en_n) begin
        m_owner[d] = -1;
      end else if (!req[m_owner[d]]) begin
        m_ptr[d] = (m_owner[d] + 1) % 4; m_owner[d] = -1;
      end else if (m_held[d] == hold_of[d]) begin
        m_ptr[d] = (m_owner[d] + 1) % 4; m_owner[d] = -1; m_to[d] = 1'b1;
      end else begin
        m_held[d]++;
      end
    end
    m_live = 1'b1;
  end

  // scoreboard: every cycle, both instances against the model
  always @(negedge clk) begin
    logic [3:0] e_gnt;
    logic [1:0] e_idx;
    if (m_live) begin
      for (int d = 0; d < 2; d++) begin
        e_gnt = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'd0;
        e_idx = (m_owner[d] >= 0) ? 2'(m_owner[d]) : 2'd0;
        check($sformatf("model_gnt[%0d]", d), 8'(o_gnt[d]), 8'(e_gnt));
        check($sformatf("model_idx[%0d]", d), 8'(o_idx[d]), 8'(e_idx));
        check($sformatf("model_vld[%0d]", d), 8'(o_vld[d]), 8'(m_owner[d] >= 0));
        check($sformatf("model_to[%0d]", d),  8'(o_to[d]),  8'(m_to[d]));
      end
    end
  end

  // driver
  task automatic apply(input logic r, input logic e, input logic [3:0] q);
    rst_n = r; en_n = e; req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input int d, input string nm, input logic [3:0] g,
                         input logic [1:0] ix, input logic v, input logic t);
    check({nm, "_gnt"}, 8'(o_gnt[d]), 8'(g));
    check({nm, "_idx"}, 8'(o_idx[d]), 8'(ix));
    check({nm, "_vld"}, 8'(o_vld[d]), 8'(v));
    check({nm, "_to"},  8'(o_to[d]),  8'(t));
  endtask

  typedef struct {
    logic       rst_n;
    logic       en_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [3:0] g,
                              logic [1:0] ix, logic v, logic t);
    vec_t x;
    x.rst_n = r; x.en_n = e; x.req = q; x.gnt = g; x.idx = ix; x.vld = v; x.to = t;
    return x;
  endfunction

  initial begin
    logic [3:0] q;
    rst_n = 1'b0; en_n = 1'b0; req = 4'hf;

    // reset, single request/release, enable gating, round robin (HOLD_MAX=8 instance)
    vecs.push_back(mk(0, 0, 4'hf, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'hf, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'hf, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'h4, 4'h4, 2, 1, 0));
    vecs.push_back(mk(1, 0, 4'h4, 4'h4, 2, 1, 0));
    vecs.push_back(mk(1, 0, 4'h4, 4'h4, 2, 1, 0));
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'hf, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 4'he, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h2, 1, 1, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h2, 1, 1, 0));
    vecs.push_back(mk(1, 0, 4'hd, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h4, 2, 1, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h4, 2, 1, 0));
    vecs.push_back(mk(1, 0, 4'hb, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h8, 3, 1, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h8, 3, 1, 0));
    vecs.push_back(mk(1, 0, 4'h7, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'hf, 4'h1, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].en_n, vecs[i].req);
      chk_out(0, $sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld, vecs[i].to);
    end

    // timeout at HOLD_MAX=8 on instance a
    apply(0, 0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      apply(1, 0, 4'h3);
      chk_out(0, $sformatf("hold%0d", i), 4'h1, 0, 1, 0);
    end
    apply(1, 0, 4'h3);
    chk_out(0, "expire", 4'h0, 0, 0, 1);
    apply(1, 0, 4'h3);
    chk_out(0, "after_expire", 4'h2, 1, 1, 0);

    // abort keeps pointer: get requester 3 granted, then disable
    apply(1, 0, 4'h8);
    chk_out(0, "rel1", 4'h0, 0, 0, 0);
    apply(1, 0, 4'h8);
    chk_out(0, "gnt3", 4'h8, 3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 4'h9);
      chk_out(0, $sformatf("abort%0d", i), 4'h0, 0, 0, 0);
    end
    apply(1, 0, 4'h9);
    chk_out(0, "regrant3", 4'h8, 3, 1, 0);

    // release coincident with expiry on HOLD_MAX=4 instance b
    apply(0, 0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 4'h2);
      chk_out(1, $sformatf("b_hold%0d", i), 4'h2, 1, 1, 0);
    end
    apply(1, 0, 4'h0);
    chk_out(1, "b_coincide", 4'h0, 0, 0, 0);
    apply(1, 0, 4'h5);
    chk_out(1, "b_ptr2", 4'h4, 2, 1, 0);

    // randomized traffic, checked by the model scoreboard
    q = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 3) q = 4'($urandom_range(0, 15));
      apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0), q);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
